// File: rtl/ccsds_iq_axis_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ccsds_iq_axis_packer: packs I/Q pairs into marker-tagged words, buffers  |
// | them in a circular FIFO and streams them out as framed AXI4-Stream.      |
// | Optional drop counter: define CCSDS_TX_DROP_CNT_EN.                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ccsds_iq_axis_packer #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int SAMPLE_WIDTH         = 13,
    parameter int FIFO_DEPTH           = 16,
    parameter int FRAME_LEN            = 256
) (
    input  logic                                M_AXIS_ACLK,
    input  logic                                M_AXIS_ARESETN,
    input  logic [SAMPLE_WIDTH-1:0]             i_data_i,
    input  logic [SAMPLE_WIDTH-1:0]             q_data_i,
    input  logic                                valid_i,
    input  logic                                clr_overflow_i,
    output logic                                overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]         fifo_level_o,
    output logic [15:0]                         drop_cnt_o,
    output logic                                M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
    output logic                                M_AXIS_TLAST,
    input  logic                                M_AXIS_TREADY
);

    localparam int HALF_W    = C_M_AXIS_TDATA_WIDTH / 2;
    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int COUNT_W   = PTR_WIDTH + 1;
    localparam int BEAT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(FRAME_LEN - 1);
    localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(FIFO_DEPTH);

    logic [C_M_AXIS_TDATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [COUNT_W-1:0]              count_q, count_d;
    logic                            tvalid_q, tvalid_d;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [BEAT_W-1:0]               beat_q, beat_d;
    logic                            overflow_q, overflow_d;

    logic [HALF_W-1:0] w_hi, w_lo;
    logic w_full, w_empty, w_pop, w_push, w_drop, w_hs;

    // Samples sit left-justified directly under the two marker bits.
    always_comb begin
        w_hi = '0;
        w_lo = '0;
        w_hi[HALF_W-1 -: 2]            = 2'b10;
        w_hi[HALF_W-3 -: SAMPLE_WIDTH] = i_data_i;
        w_lo[HALF_W-1 -: 2]            = 2'b01;
        w_lo[HALF_W-3 -: SAMPLE_WIDTH] = q_data_i;
    end

    assign w_full  = (count_q == COUNT_FULL);
    assign w_empty = (count_q == '0);
    assign w_hs    = tvalid_q && M_AXIS_TREADY;
    assign w_pop   = !w_empty && (!tvalid_q || M_AXIS_TREADY);
    assign w_push  = valid_i && (!w_full || w_pop);
    assign w_drop  = valid_i && w_full && !w_pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tvalid_d   = tvalid_q;
        tdata_d    = tdata_q;
        beat_d     = beat_q;
        overflow_d = overflow_q;
        count_d    = count_q + COUNT_W'(w_push) - COUNT_W'(w_pop);
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
        end
        // A write into an empty FIFO never bypasses; it is popped next cycle.
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
            tdata_d  = fifo_mem_q[rd_ptr_q];
            tvalid_d = 1'b1;
        end else if (w_hs) begin
            tvalid_d = 1'b0;
        end
        if (w_hs) begin
            beat_d = (beat_q == BEAT_LAST) ? '0 : beat_q + BEAT_W'(1);
        end
        if (w_drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge M_AXIS_ACLK) begin
        if (w_push) begin
            fifo_mem_q[wr_ptr_q] <= {w_hi, w_lo};
        end
    end

    always_ff @(posedge M_AXIS_ACLK) begin
        if (!M_AXIS_ARESETN) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            beat_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            beat_q     <= beat_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef CCSDS_TX_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // A drop coinciding with a clear leaves exactly that one drop counted.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clr_overflow_i) begin
            drop_cnt_d = w_drop ? 16'd1 : 16'd0;
        end else if (w_drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge M_AXIS_ACLK) begin
        if (!M_AXIS_ARESETN) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    assign drop_cnt_o = '0;
`endif

    assign overflow_o    = overflow_q;
    assign fifo_level_o  = count_q;
    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TSTRB  = '1;
    assign M_AXIS_TLAST  = tvalid_q && (beat_q == BEAT_LAST);

endmodule
`default_nettype wire

// File: tb/tb_ccsds_iq_axis_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ccsds_iq_axis_packer: scoreboard bench for ccsds_iq_axis_packer.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ccsds_iq_axis_packer;

    localparam int DW    = 32;
    localparam int SW    = 13;
    localparam int DEPTH = 16;
    localparam int FL    = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [SW-1:0] i_data = '0;
    logic [SW-1:0] q_data = '0;
    logic          valid = 1'b0;
    logic          clr = 1'b0;
    logic          tready = 1'b0;
    logic          overflow;
    logic [4:0]    level;
    logic [15:0]   drop_cnt;
    logic          tvalid;
    logic [DW-1:0] tdata;
    logic [3:0]    tstrb;
    logic          tlast;

    ccsds_iq_axis_packer #(
        .C_M_AXIS_TDATA_WIDTH(DW),
        .SAMPLE_WIDTH        (SW),
        .FIFO_DEPTH          (DEPTH),
        .FRAME_LEN           (FL)
    ) dut (
        .M_AXIS_ACLK   (clk),
        .M_AXIS_ARESETN(rstn),
        .i_data_i      (i_data),
        .q_data_i      (q_data),
        .valid_i       (valid),
        .clr_overflow_i(clr),
        .overflow_o    (overflow),
        .fifo_level_o  (level),
        .drop_cnt_o    (drop_cnt),
        .M_AXIS_TVALID (tvalid),
        .M_AXIS_TDATA  (tdata),
        .M_AXIS_TSTRB  (tstrb),
        .M_AXIS_TLAST  (tlast),
        .M_AXIS_TREADY (tready)
    );

    always #5 clk = ~clk;

    int    nchecks = 0;
    int    nerr = 0;
    exp_t  q_exp[$];
    int    occ = 0;      // samples accepted but not yet handed over
    int    acc = 0;      // samples accepted since reset
    bit    m_ovf = 1'b0;
    int    m_drops = 0;
    int    beats = 0;
    int    tlasts = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pack(input logic [SW-1:0] i, input logic [SW-1:0] q);
        logic [15:0] hi;
        logic [15:0] lo;
        hi = 16'h8000 | (16'(i) << 1);
        lo = 16'h4000 | (16'(q) << 1);
        return {hi, lo};
    endfunction

    // Capacity is DEPTH+1; a sample is lost only when everything is occupied
    // and no beat leaves in the same cycle.
    task automatic drive(input bit v, input logic [SW-1:0] i, input logic [SW-1:0] q,
                         input bit rdy, input bit c);
        bit hs;
        bit dropped;
        @(negedge clk);
        valid = v; i_data = i; q_data = q; tready = rdy; clr = c;
        hs = tvalid && rdy;
        dropped = 1'b0;
        if (v) begin
            if (occ == DEPTH + 1 && !hs) begin
                dropped = 1'b1;
            end else begin
                q_exp.push_back('{data: pack(i, q), last: ((acc % FL) == FL - 1)});
                acc++;
                occ++;
            end
        end
        if (hs) occ--;
        if (dropped) begin
            m_ovf = 1'b1;
            m_drops = c ? 1 : ((m_drops == 65535) ? m_drops : m_drops + 1);
        end else if (c) begin
            m_ovf = 1'b0;
            m_drops = 0;
        end
    endtask

    task automatic idle(input bit rdy);
        drive(1'b0, '0, '0, rdy, 1'b0);
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_overflow"}, DW'(overflow), DW'(m_ovf));
`ifdef CCSDS_TX_DROP_CNT_EN
        chk({tag, "_drop_cnt"}, DW'(drop_cnt), DW'(m_drops));
`else
        chk({tag, "_drop_cnt"}, DW'(drop_cnt), 0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; valid = 1'b0; tready = 1'b0; clr = 1'b0; i_data = '0; q_data = '0;
        q_exp.delete();
        occ = 0; acc = 0; m_ovf = 1'b0; m_drops = 0;
        repeat (2) @(negedge clk);
        chk("rst_tvalid", DW'(tvalid), 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tlast", DW'(tlast), 0);
        chk("rst_overflow", DW'(overflow), 0);
        chk("rst_level", DW'(level), 0);
        chk("rst_drop_cnt", DW'(drop_cnt), 0);
        rstn = 1'b1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((q_exp.size() != 0 || tvalid) && n < 200) begin
            idle(1'b1);
            n++;
        end
        idle(1'b1);
        chk({tag, "_drained"}, DW'(q_exp.size()), 0);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    initial begin
        bit            stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic          prev_last = 1'b0;
        exp_t          e;
        forever begin
            @(negedge clk);
            #1;
            if (!rstn) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("stall_tvalid", DW'(tvalid), 1);
                    chk("stall_tdata", tdata, prev_data);
                    chk("stall_tlast", DW'(tlast), DW'(prev_last));
                end
                if (tvalid && tready) begin
                    beats++;
                    if (tlast) tlasts++;
                    if (q_exp.size() == 0) begin
                        nchecks++;
                        nerr++;
                        $display("FAIL unexpected_beat: got %h expected none at %0t", tdata, $time);
                    end else begin
                        e = q_exp.pop_front();
                        chk("beat_tdata", tdata, e.data);
                        chk("beat_tlast", DW'(tlast), DW'(e.last));
                    end
                end
                stall = tvalid && !tready;
                prev_data = tdata;
                prev_last = tlast;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0;
        int t0;
        int pct;

        // Single sample latency and packing.
        do_reset();
        chk("tstrb", DW'(tstrb), 32'hF);
        drive(1'b1, 13'h1ABC, 13'h0123, 1'b1, 1'b0);
        idle(1'b1);
        chk("lat_cycle1_tvalid", DW'(tvalid), 0);
        idle(1'b1);
        chk("lat_cycle2_tvalid", DW'(tvalid), 1);
        chk("lat_cycle2_tdata", tdata, 32'hB578_4246);
        idle(1'b1);
        chk("lat_cycle3_tvalid", DW'(tvalid), 0);

        // 40 back-to-back samples: no gaps, TLAST on beats 16 and 32.
        do_reset();
        b0 = beats; t0 = tlasts;
        for (int k = 0; k < 40; k++) begin
            drive(1'b1, SW'($urandom), SW'($urandom), 1'b1, 1'b0);
            if (k >= 2) chk("stream_no_gap", DW'(tvalid), 1);
        end
        drain("stream");
        chk("stream_beats", DW'(beats - b0), 40);
        chk("stream_tlasts", DW'(tlasts - t0), 2);
        check_status("stream");

        // Stalled sink: 17 retained, 3 dropped.
        do_reset();
        for (int k = 0; k < 20; k++) drive(1'b1, SW'($urandom), SW'($urandom), 1'b0, 1'b0);
        idle(1'b0);
        chk("ovf_level", DW'(level), 16);
        chk("ovf_flag", DW'(overflow), 1);
`ifdef CCSDS_TX_DROP_CNT_EN
        chk("ovf_drop_cnt", DW'(drop_cnt), 3);
`else
        chk("ovf_drop_cnt", DW'(drop_cnt), 0);
`endif
        check_status("ovf");
        b0 = beats;
        drain("ovf");
        chk("ovf_beats", DW'(beats - b0), 17);
        drive(1'b0, '0, '0, 1'b1, 1'b1);
        idle(1'b1);
        check_status("ovf_clr");
        chk("ovf_clr_flag", DW'(overflow), 0);

        // Drop in the same cycle as the clear.
        for (int k = 0; k < 18; k++) drive(1'b1, SW'($urandom), SW'($urandom), 1'b0, 1'b0);
        drive(1'b1, SW'($urandom), SW'($urandom), 1'b0, 1'b1);
        idle(1'b0);
        chk("clr_drop_flag", DW'(overflow), 1);
        check_status("clr_drop");
        drain("clr_drop");

        // Full FIFO with simultaneous write and pop.
        do_reset();
        for (int k = 0; k < 17; k++) drive(1'b1, SW'($urandom), SW'($urandom), 1'b0, 1'b0);
        idle(1'b0);
        chk("full_level_before", DW'(level), 16);
        drive(1'b1, SW'($urandom), SW'($urandom), 1'b1, 1'b0);
        idle(1'b0);
        chk("full_level_after", DW'(level), 16);
        chk("full_overflow", DW'(overflow), 0);
        drain("full");

        // TREADY toggling through one frame.
        do_reset();
        b0 = beats; t0 = tlasts;
        for (int k = 0; k < 16; k++) drive(1'b1, SW'($urandom), SW'($urandom), (k % 2) == 0, 1'b0);
        for (int k = 0; k < 40; k++) idle((k % 2) == 0);
        drain("toggle");
        chk("toggle_beats", DW'(beats - b0), 16);
        chk("toggle_tlasts", DW'(tlasts - t0), 1);

        // Randomised traffic with varying sink pressure and occasional clears.
        do_reset();
        for (int seg = 0; seg < 12; seg++) begin
            pct = $urandom_range(10, 100);
            for (int k = 0; k < 200; k++) begin
                drive($urandom_range(0, 3) != 0, SW'($urandom), SW'($urandom),
                      $urandom_range(1, 100) <= pct, $urandom_range(0, 59) == 0);
            end
            idle(1'b0);
            check_status("rand");
        end
        drain("rand");

        // Reset mid-frame after five beats.
        do_reset();
        b0 = beats;
        for (int k = 0; k < 7; k++) drive(1'b1, SW'($urandom), SW'($urandom), 1'b1, 1'b0);
        chk("midrst_beats", DW'(beats - b0), 4);
        do_reset();
        t0 = tlasts;
        for (int k = 0; k < 20; k++) drive(1'b1, SW'($urandom), SW'($urandom), 1'b1, 1'b0);
        drain("midrst");
        chk("midrst_tlasts", DW'(tlasts - t0), 1);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
`default_nettype wire
